// File: rtl/accel_pkg.sv
// ADXL345 register map, command bits and FSM encodings shared by the
// accelerometer SPI reader and its byte shifter.
package accel_pkg;

  localparam logic [7:0] REG_DATA_FORMAT = 8'h31;
  localparam logic [7:0] REG_POWER_CTL   = 8'h2D;
  localparam logic [7:0] REG_DATAX0      = 8'h32;

  localparam logic [7:0] FMT_VAL = 8'h00;
  localparam logic [7:0] PWR_VAL = 8'h08;

  localparam logic [7:0] CMD_READ  = 8'h80;
  localparam logic [7:0] CMD_MB    = 8'h40;
  localparam logic [7:0] CMD_BURST =
    CMD_READ | CMD_MB | REG_DATAX0;

  localparam logic [9:0] MIDSCALE = 10'd512;

  localparam logic [2:0] S_STARTUP = 3'd0;
  localparam logic [2:0] S_WR_FMT  = 3'd1;
  localparam logic [2:0] S_WR_PWR  = 3'd2;
  localparam logic [2:0] S_IDLE    = 3'd3;
  localparam logic [2:0] S_READ    = 3'd4;
  localparam logic [2:0] S_UPDATE  = 3'd5;

  typedef enum logic [1:0] {
    PH_SETUP,
    PH_SHIFT,
    PH_HOLD,
    PH_GAP
  } phase_t;

  // 10-bit two's complement sample -> offset binary
  function automatic logic [9:0] to_offset(
    input logic [7:0] b0,
    input logic [7:0] b1
  );
    return {~b1[1], b1[0], b0};
  endfunction

endpackage

// File: rtl/adxl345_spi_reader_if.sv
// 4-wire SPI link between the reader (master) and the ADXL345 (slave).
interface adxl345_spi_reader_if;
  logic spi_sclk;
  logic spi_cs_n;
  logic spi_mosi;
  logic spi_miso;

  modport master (
    output spi_sclk,
    output spi_cs_n,
    output spi_mosi,
    input  spi_miso
  );

  modport slave (
    input  spi_sclk,
    input  spi_cs_n,
    input  spi_mosi,
    output spi_miso
  );
endinterface

// File: rtl/adxl345_spi_reader_shifter.sv
// Mode-3 SPI byte engine: one start shifts 8 bits MSB first and
// returns the received byte with a done pulse.
module spi_byte_shifter #(
  parameter int HALF_DIV = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] tx,
  output logic [7:0] rx,
  output logic       done,
  output logic       sclk,
  output logic       mosi,
  input  logic       miso
);
  localparam int CW = $clog2(HALF_DIV + 1);

  logic          busy;
  logic [CW-1:0] cnt;
  logic [3:0]    edges;
  logic [7:0]    sh;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy  <= 1'b0;
      cnt   <= '0;
      edges <= '0;
      sh    <= '0;
      rx    <= '0;
      done  <= 1'b0;
      sclk  <= 1'b1;
      mosi  <= 1'b1;
    end else begin
      done <= 1'b0;
      if (start && !busy) begin
        busy  <= 1'b1;
        cnt   <= '0;
        edges <= '0;
        sh    <= tx;
      end else if (busy) begin
        if (cnt == CW'(HALF_DIV - 1)) begin
          cnt   <= '0;
          edges <= edges + 4'd1;
          if (sclk) begin
            sclk <= 1'b0;
            mosi <= sh[7];
            sh   <= {sh[6:0], 1'b0};
          end else begin
            // miso has been stable since the preceding fall
            sclk <= 1'b1;
            rx   <= {rx[6:0], miso};
            if (edges == 4'd15) begin
              busy <= 1'b0;
              done <= 1'b1;
            end
          end
        end else begin
          cnt <= cnt + CW'(1);
        end
      end
    end
  end

endmodule

// File: rtl/adxl345_spi_reader.sv
// ADXL345 reader: configures the part after reset, then burst-reads
// X/Y/Z at the sample rate and presents offset-binary axes.
module adxl345_spi_reader #(
  parameter int CLK_FREQ       = 50_000_000,
  parameter int SPI_FREQ       = 2_000_000,
  parameter int SAMPLE_HZ      = 100,
  parameter int STARTUP_CYCLES = 100_000,
  parameter int DATA_WIDTH     = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  adxl345_spi_reader_if.master  spi,
  output logic [DATA_WIDTH-1:0] x_out,
  output logic [DATA_WIDTH-1:0] y_out,
  output logic [DATA_WIDTH-1:0] z_out,
  output logic                  data_valid,
  output logic                  init_done
);
  import accel_pkg::*;

  localparam int HALF_DIV   = CLK_FREQ / (2 * SPI_FREQ);
  localparam int SAMPLE_DIV = CLK_FREQ / SAMPLE_HZ;

  logic [2:0]       state;
  phase_t           ph;
  logic [2:0]       idx;
  logic [31:0]      cnt;
  logic [31:0]      scnt;
  logic             pending;
  logic             cs_n;
  logic             start;
  logic [5:0][7:0]  rxb;
  logic [7:0]       tx_byte;
  logic [7:0]       rx_byte;
  logic             sh_done;
  logic             tick;
  logic             enter_read;
  logic [2:0]       last;

  assign spi.spi_cs_n = cs_n;
  assign tick = scnt == 32'(SAMPLE_DIV - 1);
  assign enter_read =
    state == S_IDLE && pending && enable;
  assign last = state == S_READ ? 3'd6 : 3'd1;

  always_comb begin
    tx_byte = 8'h00;
    unique case (1'b1)
      state == S_WR_FMT:
        tx_byte = idx == 3'd0 ? REG_DATA_FORMAT : FMT_VAL;
      state == S_WR_PWR:
        tx_byte = idx == 3'd0 ? REG_POWER_CTL : PWR_VAL;
      state == S_READ:
        tx_byte = idx == 3'd0 ? CMD_BURST : 8'h00;
      default: ;
    endcase
  end

  spi_byte_shifter #(.HALF_DIV(HALF_DIV)) u_shift (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .tx    (tx_byte),
    .rx    (rx_byte),
    .done  (sh_done),
    .sclk  (spi.spi_sclk),
    .mosi  (spi.spi_mosi),
    .miso  (spi.spi_miso)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      scnt    <= '0;
      pending <= 1'b0;
    end else begin
      scnt <= tick ? '0 : scnt + 32'd1;
      if (enter_read) pending <= 1'b0;
      else if (tick)  pending <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_STARTUP;
      ph         <= PH_SETUP;
      idx        <= '0;
      cnt        <= '0;
      cs_n       <= 1'b1;
      start      <= 1'b0;
      rxb        <= '0;
      x_out      <= DATA_WIDTH'(MIDSCALE);
      y_out      <= DATA_WIDTH'(MIDSCALE);
      z_out      <= DATA_WIDTH'(MIDSCALE);
      data_valid <= 1'b0;
      init_done  <= 1'b0;
    end else begin
      start      <= 1'b0;
      data_valid <= 1'b0;
      case (state)
        S_STARTUP: begin
          if (cnt == 32'(STARTUP_CYCLES - 1)) begin
            cnt   <= '0;
            state <= S_WR_FMT;
            ph    <= PH_SETUP;
            idx   <= '0;
            cs_n  <= 1'b0;
          end else begin
            cnt <= cnt + 32'd1;
          end
        end
        S_WR_FMT, S_WR_PWR, S_READ: begin
          case (ph)
            PH_SETUP: begin
              if (cnt == 32'(HALF_DIV - 1)) begin
                cnt   <= '0;
                ph    <= PH_SHIFT;
                start <= 1'b1;
              end else begin
                cnt <= cnt + 32'd1;
              end
            end
            PH_SHIFT: begin
              if (sh_done) begin
                if (state == S_READ && idx != 3'd0)
                  rxb[idx - 3'd1] <= rx_byte;
                if (idx == last) begin
                  ph <= PH_HOLD;
                end else begin
                  idx   <= idx + 3'd1;
                  start <= 1'b1;
                end
              end
            end
            PH_HOLD: begin
              if (cnt == 32'(HALF_DIV - 1)) begin
                cnt  <= '0;
                cs_n <= 1'b1;
                ph   <= PH_GAP;
              end else begin
                cnt <= cnt + 32'd1;
              end
            end
            default: begin
              // enforce CS-high gap before any next frame
              if (cnt == 32'(2 * HALF_DIV - 1)) begin
                cnt <= '0;
                ph  <= PH_SETUP;
                idx <= '0;
                case (state)
                  S_WR_FMT: begin
                    state <= S_WR_PWR;
                    cs_n  <= 1'b0;
                  end
                  S_WR_PWR: begin
                    state     <= S_IDLE;
                    init_done <= 1'b1;
                  end
                  default: state <= S_UPDATE;
                endcase
              end else begin
                cnt <= cnt + 32'd1;
              end
            end
          endcase
        end
        S_IDLE: begin
          if (enter_read) begin
            state <= S_READ;
            ph    <= PH_SETUP;
            idx   <= '0;
            cnt   <= '0;
            cs_n  <= 1'b0;
          end
        end
        S_UPDATE: begin
          x_out      <= DATA_WIDTH'(to_offset(rxb[0], rxb[1]));
          y_out      <= DATA_WIDTH'(to_offset(rxb[2], rxb[3]));
          z_out      <= DATA_WIDTH'(to_offset(rxb[4], rxb[5]));
          data_valid <= 1'b1;
          state      <= S_IDLE;
        end
        default: state <= S_STARTUP;
      endcase
    end
  end

endmodule
